// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and defaults for the cache request-port arbiter.
package cache_port_arbiter_pkg;

    localparam int addressBusWidth   = 16;
    localparam int wordSize          = 8;
    localparam int ArbTimeoutDefault = 1024;

    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t;

    // Index width for a requester vector; never zero even for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module cache_rr_pick
    import cache_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        j     = 0;
        // Scan from farthest to nearest so the nearest hit overwrites the rest.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache port, with a stall watchdog.
// Optional counters enabled by defining CACHE_ARB_STATS_EN.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = addressBusWidth,
    parameter int DATA_W      = wordSize,
    parameter int TIMEOUT_CYC = ArbTimeoutDefault
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      cache_req,
    output logic                      cache_we_L,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic [DATA_W-1:0]         cache_wdata,
    input  logic [DATA_W-1:0]         cache_rdata,
    input  logic                      cache_done,
    output logic                      busy
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants,
    output logic [15:0]               stat_timeouts
`endif
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    arb_state_t           state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_grant;
    logic                 win_we;
    logic [CW-1:0]        wait_cnt;
    logic                 timeout;

    cache_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign req_ready = (state == ARB_IDLE) ? pick_grant : '0;
    assign busy      = (state != ARB_IDLE);
    assign timeout   = (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            win_idx     <= '0;
            win_we      <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            cache_req   <= 1'b0;
            cache_we_L  <= 1'b1;
            cache_addr  <= '0;
            cache_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req_valid) begin
                        cache_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        cache_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        cache_we_L  <= ~req_we[pick_idx];
                        win_we      <= req_we[pick_idx];
                        win_idx     <= pick_idx;
                        cache_req   <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A completion arriving in the last watchdog cycle still counts as success.
                    if (cache_done) begin
                        cache_req <= 1'b0;
                        rsp_rdata <= win_we ? '0 : cache_rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << win_idx;
                        state     <= ARB_RESP;
                    end else if (timeout) begin
                        cache_req <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << win_idx;
                        state     <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    rsp_valid <= '0;
                    rr_ptr    <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    wait_cnt  <= '0;
                    state     <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef CACHE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (state == ARB_IDLE && |req_valid && stat_grants[pick_idx*16 +: 16] != 16'hFFFF)
                stat_grants[pick_idx*16 +: 16] <= stat_grants[pick_idx*16 +: 16] + 16'd1;
            if (state == ARB_WAIT && !cache_done && timeout && stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench: default-timeout instance for function, 16-cycle instance for the watchdog.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // main instance (default watchdog)
    logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [63:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rsp_rdata, cache_wdata, cache_rdata;
    logic        rsp_err, cache_req, cache_we_L, cache_done, busy;
    logic [15:0] cache_addr;

    // short-watchdog instance
    logic [3:0]  t_req_valid, t_req_we, t_req_ready, t_rsp_valid;
    logic [63:0] t_req_addr;
    logic [31:0] t_req_wdata;
    logic [7:0]  t_rsp_rdata, t_cache_wdata, t_cache_rdata;
    logic        t_rsp_err, t_cache_req, t_cache_we_L, t_cache_done, t_busy;
    logic [15:0] t_cache_addr;

`ifdef CACHE_ARB_STATS_EN
    logic [63:0] stat_grants, t_stat_grants;
    logic [15:0] stat_timeouts, t_stat_timeouts;
`endif

    int total  = 0;
    int passed = 0;

    cache_port_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cache_req(cache_req), .cache_we_L(cache_we_L), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_done(cache_done),
        .busy(busy)
`ifdef CACHE_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_timeouts(stat_timeouts)
`endif
    );

    cache_port_arbiter #(.TIMEOUT_CYC(16)) u_to (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_we(t_req_we), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
        .req_ready(t_req_ready), .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
        .cache_req(t_cache_req), .cache_we_L(t_cache_we_L), .cache_addr(t_cache_addr),
        .cache_wdata(t_cache_wdata), .cache_rdata(t_cache_rdata), .cache_done(t_cache_done),
        .busy(t_busy)
`ifdef CACHE_ARB_STATS_EN
        , .stat_grants(t_stat_grants), .stat_timeouts(t_stat_timeouts)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [3:0] exp_oh;

        reset = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        cache_rdata = '0; cache_done = 1'b0;
        t_req_valid = '0; t_req_we = '0; t_req_addr = '0; t_req_wdata = '0;
        t_cache_rdata = '0; t_cache_done = 1'b0;
        repeat (2) tick();

        // reset state
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_cache_req", 32'(cache_req), 0);
        chk("rst_cache_we_L", 32'(cache_we_L), 1);
        chk("rst_cache_addr", 32'(cache_addr), 0);
        chk("rst_cache_wdata", 32'(cache_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_t_busy", 32'(t_busy), 0);
        reset = 1'b0;

        // single read, cache answers 20 cycles after accept
        req_valid = 4'b0001; req_addr[15:0] = 16'h1A4F; #1;
        chk("rd_ready", 32'(req_ready), 32'h1);
        tick();
        chk("rd_ready_wait", 32'(req_ready), 0);
        chk("rd_cache_req", 32'(cache_req), 1);
        chk("rd_cache_addr", 32'(cache_addr), 32'h1A4F);
        chk("rd_cache_we_L", 32'(cache_we_L), 1);
        chk("rd_busy", 32'(busy), 1);
        req_valid = '0;
        repeat (19) tick();
        chk("rd_no_early_rsp", 32'(rsp_valid), 0);
        cache_done = 1'b1; cache_rdata = 8'hDD;
        tick();
        cache_done = 1'b0; cache_rdata = '0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hDD);
        chk("rd_rsp_err", 32'(rsp_err), 0);
        chk("rd_cache_req_low", 32'(cache_req), 0);
        tick();
        chk("rd_rsp_pulse", 32'(rsp_valid), 0);
        chk("rd_idle", 32'(busy), 0);

        // round-robin from a fresh pointer, all four holding reads
        reset = 1'b1; tick(); reset = 1'b0;
        req_addr = 64'h4444_3333_2222_1111;
        req_valid = 4'b1111; #1;
        for (int n = 0; n < 5; n++) begin
            exp_oh = 4'b0001 << (n % 4);
            chk("rr_ready", 32'(req_ready), 32'(exp_oh));
            tick();
            repeat (2) tick();
            cache_done = 1'b1; cache_rdata = 8'h10 + 8'(n);
            tick();
            cache_done = 1'b0;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(exp_oh));
            chk("rr_rsp_rdata", 32'(rsp_rdata), 32'h10 + n);
            tick();
        end
        req_valid = '0; cache_rdata = '0;

        // write from requester 2; operands must stay put while waiting
        req_valid = 4'b0100; req_we = 4'b0100;
        req_wdata[23:16] = 8'hED; req_addr[47:32] = 16'h0BEE; #1;
        chk("wr_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0; req_we = '0; req_wdata = '0;
        for (int n = 0; n < 3; n++) begin
            chk("wr_we_L", 32'(cache_we_L), 0);
            chk("wr_wdata", 32'(cache_wdata), 32'hED);
            chk("wr_addr", 32'(cache_addr), 32'h0BEE);
            tick();
        end
        cache_done = 1'b1; cache_rdata = 8'h55;
        tick();
        cache_done = 1'b0; cache_rdata = '0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("wr_rsp_rdata", 32'(rsp_rdata), 0);
        chk("wr_cache_req", 32'(cache_req), 0);
        tick();

        // reset three cycles into WAIT: pointer (now 3) returns to 0
        req_valid = 4'b0010; #1;
        chk("rm_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_cache_req", 32'(cache_req), 0);
        chk("rm_rsp_valid", 32'(rsp_valid), 0);
        chk("rm_busy", 32'(busy), 0);
        req_valid = 4'b1111; #1;
        chk("rm_ptr_zero", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("rm_no_stale_rsp", 32'(rsp_valid), 0);
        tick();
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        chk("rm_rsp_valid", 32'(rsp_valid), 32'h1);
        tick();

        // short watchdog instance: five quick grants to requester 1
        for (int n = 0; n < 5; n++) begin
            t_req_valid = 4'b0010; t_req_addr[31:16] = 16'h2000 + 16'(n); #1;
            chk("t_g1_ready", 32'(t_req_ready), 32'h2);
            tick();
            t_req_valid = '0;
            tick();
            t_cache_done = 1'b1; t_cache_rdata = 8'hA0 + 8'(n);
            tick();
            t_cache_done = 1'b0;
            chk("t_g1_rsp_valid", 32'(t_rsp_valid), 32'h2);
            chk("t_g1_rdata", 32'(t_rsp_rdata), 32'hA0 + n);
            tick();
        end
        t_cache_rdata = '0;

        // timeout: no completion at all
        t_req_valid = 4'b1000; t_req_addr[63:48] = 16'h3333; #1;
        chk("to_ready", 32'(t_req_ready), 32'h8);
        tick();
        t_req_valid = '0;
        repeat (15) tick();
        chk("to_req_held", 32'(t_cache_req), 1);
        chk("to_addr_held", 32'(t_cache_addr), 32'h3333);
        chk("to_we_L", 32'(t_cache_we_L), 1);
        chk("to_wdata", 32'(t_cache_wdata), 0);
        chk("to_no_rsp_yet", 32'(t_rsp_valid), 0);
        tick();
        chk("to_cache_req_low", 32'(t_cache_req), 0);
        chk("to_rsp_valid", 32'(t_rsp_valid), 32'h8);
        chk("to_rsp_err", 32'(t_rsp_err), 1);
        chk("to_rsp_rdata", 32'(t_rsp_rdata), 0);
        tick();
        chk("to_rsp_pulse", 32'(t_rsp_valid), 0);
        chk("to_idle", 32'(t_busy), 0);

        // next request after a timeout completes normally
        t_req_valid = 4'b0001; #1;
        chk("ta_ready", 32'(t_req_ready), 32'h1);
        tick();
        t_req_valid = '0;
        tick();
        t_cache_done = 1'b1; t_cache_rdata = 8'h3C;
        tick();
        t_cache_done = 1'b0;
        chk("ta_rsp_valid", 32'(t_rsp_valid), 32'h1);
        chk("ta_rsp_err", 32'(t_rsp_err), 0);
        chk("ta_rdata", 32'(t_rsp_rdata), 32'h3C);
        tick();

        // completion in the final watchdog cycle wins over the abort
        t_req_valid = 4'b0100; #1;
        chk("tb_ready", 32'(t_req_ready), 32'h4);
        tick();
        t_req_valid = '0;
        repeat (15) tick();
        t_cache_done = 1'b1; t_cache_rdata = 8'h77;
        tick();
        t_cache_done = 1'b0; t_cache_rdata = '0;
        chk("tb_rsp_valid", 32'(t_rsp_valid), 32'h4);
        chk("tb_rsp_err", 32'(t_rsp_err), 0);
        chk("tb_rdata", 32'(t_rsp_rdata), 32'h77);
        tick();

`ifdef CACHE_ARB_STATS_EN
        chk("st_grants0", 32'(t_stat_grants[15:0]), 1);
        chk("st_grants1", 32'(t_stat_grants[31:16]), 5);
        chk("st_grants2", 32'(t_stat_grants[47:32]), 1);
        chk("st_grants3", 32'(t_stat_grants[63:48]), 1);
        chk("st_timeouts", 32'(t_stat_timeouts), 1);
        chk("st_main_timeouts", 32'(stat_timeouts), 0);
        chk("st_main_grants0", 32'(stat_grants[15:0]), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
